// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
//
// Bundles the signals between the multicycle control FSM and the shared
// datapath (single memory, one ALU, IR/OldPC/A/B/ALUOut/Data registers).
//
// Datapath -> controller (decoded IR fields and ALU flags):
//   OPC[6:0]        IR[6:0]
//   func3[2:0]      IR[14:12]
//   func7[6:0]      IR[31:25]
//   Zero, blt, bge  ALU comparison flags for A/B in the current cycle
//
// Controller -> datapath (selects and write enables):
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite
//   ResultSrc[1:0]  00=ALUOut 01=Data 10=ALU 11=Imm
//   ALUSrcA[1:0]    00=PC 01=OldPC 10=A
//   ALUSrcB[1:0]    00=B 01=Imm 10=constant 4
//   AluControl[2:0] ADD=000 SUB=001 AND=010 OR=011 SLT=101 XOR=111
//   ImmSrc[2:0]     I=000 S=001 B=010 U=011 J=100
//   Illegal         sticky unsupported-opcode flag
//   state[3:0]      raw FSM state register, for debug and checker binding
//
// Modports: master = controller, slave = datapath.
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [6:0] OPC;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       Zero;
    logic       blt;
    logic       bge;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] AluControl;
    logic [2:0] ImmSrc;
    logic       Illegal;
    logic [3:0] state;

    modport master (
        input  OPC, func3, func7, Zero, blt, bge,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, AluControl, ImmSrc,
               Illegal, state
    );

    modport slave (
        output OPC, func3, func7, Zero, blt, bge,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, AluControl, ImmSrc,
               Illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for the multicycle RV32I-subset core. Sequences the shared
// datapath over 3-5 cycles per instruction; every select and write enable is
// decoded combinationally from the registered state plus the IR fields and,
// in BRANCH, the ALU flags.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset; while high every output is forced
//        to 0 so no PC/IR/memory/register write can happen mid-reset
//   bus  multicycle_controller_if.master (IR fields and flags in, controls
//        out, plus the raw state for debug)
//
// Build option:
//   MC_ILLEGAL_TRAP_EN  when defined, an unsupported opcode sends the FSM to
//                       HALT (all controls 0, Illegal=1) until reset. When
//                       undefined, it is a 2-cycle NOP and Illegal is 0.
//
// Handshake: none; the datapath follows the controls cycle by cycle. The IR
// fields only change on IRWrite (FETCH), so they are stable from DECODE to
// the next FETCH.
// ---------------------------------------------------------------------------
module multicycle_controller (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_controller_if.master  bus
);

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b111;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Operand / result selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Opcodes
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        S_HALT     = 4'd14
`endif
    } state_t;

    state_t state;
    state_t state_next;

    // Decoded controls before reset gating
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] imm_src;

    logic       branch_taken;
    logic [2:0] r_op;
    logic [2:0] i_op;

    // Branch condition; unsupported func3 values are never taken.
    always_comb begin
        branch_taken = 1'b0;
        case (bus.func3)
            3'b000:  branch_taken = bus.Zero;
            3'b001:  branch_taken = ~bus.Zero;
            3'b100:  branch_taken = bus.blt;
            3'b101:  branch_taken = bus.bge;
            default: branch_taken = 1'b0;
        endcase
    end

    // R-type ALU op; any unsupported funct combination falls back to ADD.
    always_comb begin
        r_op = ALU_ADD;
        case (bus.func3)
            3'b000:  r_op = (bus.func7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b111:  r_op = ALU_AND;
            3'b110:  r_op = ALU_OR;
            3'b010:  r_op = ALU_SLT;
            default: r_op = ALU_ADD;
        endcase
    end

    // I-type ALU op; unsupported func3 falls back to ADD.
    always_comb begin
        i_op = ALU_ADD;
        case (bus.func3)
            3'b000:  i_op = ALU_ADD;
            3'b100:  i_op = ALU_XOR;
            3'b010:  i_op = ALU_SLT;
            3'b110:  i_op = ALU_OR;
            default: i_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_B;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;

        case (state)
            S_FETCH: begin
                // PC+4 goes straight back into PC through the ALU result path.
                ir_write    = 1'b1;
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                result_src  = RES_ALU;
                pc_write    = 1'b1;
                state_next  = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch/jal target lands in ALUOut.
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                imm_src     = (bus.OPC == OP_JAL) ? IMM_J : IMM_B;
                case (bus.OPC)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BR:        state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    OP_JALR:      state_next = S_JALR;
                    OP_LUI:       state_next = S_LUI;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_next = S_HALT;
`else
                    default:      state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = SRCA_A;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                imm_src     = (bus.OPC == OP_SW) ? IMM_S : IMM_I;
                state_next  = (bus.OPC == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                mem_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = SRCA_A;
                alu_src_b   = SRCB_B;
                alu_control = r_op;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = SRCA_A;
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_I;
                alu_control = i_op;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                // ALUOut still holds the target computed in DECODE.
                alu_src_a   = SRCA_A;
                alu_src_b   = SRCB_B;
                alu_control = ALU_SUB;
                result_src  = RES_ALUOUT;
                pc_write    = branch_taken;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                // PC <- target from ALUOut while the ALU forms OldPC+4.
                result_src  = RES_ALUOUT;
                pc_write    = 1'b1;
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                state_next  = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a   = SRCA_A;
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_I;
                alu_control = ALU_ADD;
                result_src  = RES_ALU;
                pc_write    = 1'b1;
                state_next  = S_LINK;
            end
            S_LINK: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                state_next  = S_ALUWB;
            end
            S_LUI: begin
                imm_src    = IMM_U;
                result_src = RES_IMM;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_next = S_HALT;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset forces every control low, including mid-instruction.
    assign bus.PCWrite    = pc_write   & ~rst;
    assign bus.AdrSrc     = adr_src    & ~rst;
    assign bus.MemWrite   = mem_write  & ~rst;
    assign bus.IRWrite    = ir_write   & ~rst;
    assign bus.RegWrite   = reg_write  & ~rst;
    assign bus.ResultSrc  = rst ? 2'b00  : result_src;
    assign bus.ALUSrcA    = rst ? 2'b00  : alu_src_a;
    assign bus.ALUSrcB    = rst ? 2'b00  : alu_src_b;
    assign bus.AluControl = rst ? 3'b000 : alu_control;
    assign bus.ImmSrc     = rst ? 3'b000 : imm_src;
    assign bus.state      = state;

`ifdef MC_ILLEGAL_TRAP_EN
    // HALT is only left through reset, so being in HALT is the sticky flag.
    assign bus.Illegal = (state == S_HALT) & ~rst;
`else
    assign bus.Illegal = 1'b0;
`endif

endmodule
